// File: rtl/fmul_share_ctrl.sv
// Shares one registered FP32 multiplier between two requesters: round-robin
// acceptance, operand hold for LAT edges, and a one-cycle response pulse to the issuer.
module fmul_share_ctrl #(
  parameter int unsigned LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_c,
  input  logic        mul_overflow,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_c,
  output logic        rsp_overflow,
  output logic        busy,
  output logic [15:0] op_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       last_grant;
  logic       owner;
  logic [3:0] cnt;
  logic       grant0;
  logic       grant1;
  logic       accept;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_grant);
    grant1 = req1_valid && (!req0_valid || !last_grant);
    accept = (state == IDLE) && (grant0 || grant1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = WAIT;
      WAIT:    if (cnt == 4'd1) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (state == IDLE) && grant0;
    req1_ready = (state == IDLE) && grant1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a        <= '0;
      mul_b        <= '0;
      rsp_c        <= '0;
      rsp_overflow <= 1'b0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      op_cnt       <= '0;
      busy         <= 1'b0;
      last_grant   <= 1'b1;
      owner        <= 1'b0;
      cnt          <= '0;
    end else begin
      busy       <= (state_next != IDLE);
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            mul_a      <= grant1 ? req1_a : req0_a;
            mul_b      <= grant1 ? req1_b : req0_b;
            owner      <= grant1;
            last_grant <= grant1;
            cnt        <= 4'(LAT);
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            rsp_c        <= mul_c;
            rsp_overflow <= mul_overflow;
            rsp0_valid   <= !owner;
            rsp1_valid   <= owner;
          end
        end
        RESP: begin
          op_cnt <= op_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
